// File: rtl/pipe_hazard_unit_pkg.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit_pkg: shared scoreboard types and defaults. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipe_hazard_unit_pkg;

  localparam int DEFAULT_DEPTH     = 3;
  localparam int DEFAULT_LOAD_DIST = 2;
  localparam int FWD_RF            = 0;

  // rd is stored zero-extended so the entry type stays independent of the register width
  localparam int RD_MAX_W = 16;

  typedef struct packed {
    logic                valid;
    logic                wr;
    logic [RD_MAX_W-1:0] rd;
    logic                load;
  } sb_entry_t;

endpackage

`default_nettype wire

// File: rtl/pipe_hazard_unit_sat_counter.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit_sat_counter: enable-driven up-counter that sticks at max. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_hazard_unit_sat_counter #(
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en_i,
  output logic [CNT_BITS-1:0] count_o
);

  logic [CNT_BITS-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (en_i && (count_q != {CNT_BITS{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// pipe_hazard_unit: scoreboard-based operand forwarding and load-use stall. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipe_hazard_unit
  import pipe_hazard_unit_pkg::*;
#(
  parameter int REG_INDEX_BIT_WIDTH = 4,
  parameter int NUM_SRC             = 2,
  parameter int DEPTH               = DEFAULT_DEPTH,
  parameter int LOAD_DIST           = DEFAULT_LOAD_DIST,
  parameter int CNT_BITS            = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   dec_valid,
  input  logic [NUM_SRC*REG_INDEX_BIT_WIDTH-1:0] dec_src,
  input  logic [NUM_SRC-1:0]                     dec_src_used,
  input  logic [REG_INDEX_BIT_WIDTH-1:0]         dec_rd,
  input  logic                                   dec_wr_reg,
  input  logic                                   dec_is_load,
  input  logic                                   flush,
  input  logic                                   freeze,
  output logic                                   stall,
  output logic [NUM_SRC*$clog2(DEPTH+1)-1:0]     fwd_sel,
  output logic [CNT_BITS-1:0]                    stall_count,
  output logic [CNT_BITS-1:0]                    flush_count
);

  localparam int SEL_W = $clog2(DEPTH+1);
  localparam int W     = REG_INDEX_BIT_WIDTH;

  sb_entry_t          sb_q [DEPTH];
  sb_entry_t          sb_d [DEPTH];
  logic [NUM_SRC-1:0] lu_hit;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [RD_MAX_W-1:0] src;
    logic [SEL_W-1:0]    sel;
    logic                ld_hit;

    assign src = RD_MAX_W'(dec_src[i*W +: W]);

    // Walk oldest to youngest so the nearest producer overrides older matches
    always_comb begin
      sel    = SEL_W'(FWD_RF);
      ld_hit = 1'b0;
      for (int k = DEPTH-1; k >= 0; k--) begin
        if (dec_src_used[i] && sb_q[k].valid && sb_q[k].wr && (sb_q[k].rd == src)) begin
          sel    = SEL_W'(k+1);
          ld_hit = sb_q[k].load && ((k+1) < LOAD_DIST);
        end
      end
    end

    assign fwd_sel[i*SEL_W +: SEL_W] = sel;
    assign lu_hit[i]                 = ld_hit;
  end

  assign stall = (|lu_hit) && dec_valid && !flush && !freeze;

  always_comb begin
    sb_d          = sb_q;
    sb_d[0].valid = dec_valid && !stall && !flush;
    sb_d[0].wr    = dec_wr_reg;
    sb_d[0].rd    = RD_MAX_W'(dec_rd);
    sb_d[0].load  = dec_is_load;
    for (int k = 1; k < DEPTH; k++) begin
      sb_d[k] = sb_q[k-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        sb_q[k] <= '0;
      end
    end else if (!freeze) begin
      sb_q <= sb_d;
    end
  end

  pipe_hazard_unit_sat_counter #(.CNT_BITS(CNT_BITS)) u_stall_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (stall),
    .count_o (stall_count)
  );

  pipe_hazard_unit_sat_counter #(.CNT_BITS(CNT_BITS)) u_flush_cnt (
    .clk     (clk),
    .reset   (reset),
    .en_i    (flush && !freeze),
    .count_o (flush_count)
  );

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_unit: directed checks of forwarding, stalls, flush, freeze. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_pipe_hazard_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        dec_valid;
  logic [7:0]  dec_src;
  logic [1:0]  dec_src_used;
  logic [3:0]  dec_rd;
  logic        dec_wr_reg;
  logic        dec_is_load;
  logic        flush;
  logic        freeze;

  logic        stall, stall2;
  logic [3:0]  fwd_sel, fwd_sel2;
  logic [15:0] stall_count, flush_count;
  logic [1:0]  stall_count2, flush_count2;

  int checks = 0;
  int errors = 0;

  pipe_hazard_unit #(.CNT_BITS(16)) u_dut (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_src(dec_src),
    .dec_src_used(dec_src_used), .dec_rd(dec_rd), .dec_wr_reg(dec_wr_reg),
    .dec_is_load(dec_is_load), .flush(flush), .freeze(freeze), .stall(stall),
    .fwd_sel(fwd_sel), .stall_count(stall_count), .flush_count(flush_count)
  );

  pipe_hazard_unit #(.CNT_BITS(2)) u_dut_small (
    .clk(clk), .reset(reset), .dec_valid(dec_valid), .dec_src(dec_src),
    .dec_src_used(dec_src_used), .dec_rd(dec_rd), .dec_wr_reg(dec_wr_reg),
    .dec_is_load(dec_is_load), .flush(flush), .freeze(freeze), .stall(stall2),
    .fwd_sel(fwd_sel2), .stall_count(stall_count2), .flush_count(flush_count2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] s0, input logic [3:0] s1,
                       input logic [1:0] used, input logic [3:0] rd, input logic wr,
                       input logic ld, input logic fl, input logic fz);
    dec_valid    = v;
    dec_src      = {s1, s0};
    dec_src_used = used;
    dec_rd       = rd;
    dec_wr_reg   = wr;
    dec_is_load  = ld;
    flush        = fl;
    freeze       = fz;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    #1;
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_fwd", {28'd0, fwd_sel}, 32'd0);
    chk("reset_scnt", {16'd0, stall_count}, 32'd0);
    chk("reset_fcnt", {16'd0, flush_count}, 32'd0);
    cyc(); cyc();
    reset = 1'b0;

    // No producers in flight
    drive(1, 3, 0, 2'b01, 0, 0, 0, 0, 0); #1;
    chk("noprod_stall", {31'd0, stall}, 32'd0);
    chk("noprod_fwd", {28'd0, fwd_sel}, 32'd0);

    // ALU producer r5 at distances 1..4
    drive(1, 0, 0, 2'b00, 5, 1, 0, 0, 0); cyc();
    drive(1, 5, 0, 2'b01, 0, 0, 0, 0, 0); #1;
    chk("alu_d1", {28'd0, fwd_sel}, 32'h1);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0); cyc();
    drive(1, 5, 0, 2'b01, 0, 0, 0, 0, 0); #1;
    chk("alu_d2", {28'd0, fwd_sel}, 32'h2);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0); cyc();
    drive(1, 5, 0, 2'b01, 0, 0, 0, 0, 0); #1;
    chk("alu_d3", {28'd0, fwd_sel}, 32'h3);
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0); cyc();
    drive(1, 5, 0, 2'b01, 0, 0, 0, 0, 0); #1;
    chk("alu_d4", {28'd0, fwd_sel}, 32'h0);

    // Load r7 followed by its consumer
    drive(1, 1, 0, 2'b01, 7, 1, 1, 0, 0); #1;
    chk("load_issue_stall", {31'd0, stall}, 32'd0);
    cyc();
    drive(1, 7, 0, 2'b01, 0, 0, 0, 0, 0); #1;
    chk("lu_stall", {31'd0, stall}, 32'd1);
    chk("lu_fwd", {28'd0, fwd_sel}, 32'h1);
    cyc();
    chk("lu_after_stall", {31'd0, stall}, 32'd0);
    chk("lu_after_fwd", {28'd0, fwd_sel}, 32'h2);
    chk("lu_after_scnt", {16'd0, stall_count}, 32'd1);
    cyc();

    // r2 at distances 3 and 1
    drive(1, 0, 0, 2'b00, 2, 1, 0, 0, 0); cyc();
    drive(1, 0, 0, 2'b00, 0, 0, 0, 0, 0); cyc();
    drive(1, 0, 0, 2'b00, 2, 1, 0, 0, 0); cyc();
    drive(1, 2, 2, 2'b11, 0, 0, 0, 0, 0); #1;
    chk("youngest_fwd", {28'd0, fwd_sel}, 32'h5);
    chk("youngest_stall", {31'd0, stall}, 32'd0);
    drive(1, 2, 2, 2'b01, 0, 0, 0, 0, 0); #1;
    chk("src1_unused_fwd", {28'd0, fwd_sel}, 32'h1);

    // Flush coinciding with load-use
    drive(0, 0, 0, 2'b00, 0, 0, 0, 0, 0); cyc(); cyc(); cyc();
    drive(1, 1, 0, 2'b01, 9, 1, 1, 0, 0); cyc();
    drive(1, 9, 0, 2'b01, 9, 1, 0, 1, 0); #1;
    chk("flush_stall", {31'd0, stall}, 32'd0);
    chk("flush_fwd", {28'd0, fwd_sel}, 32'h1);
    cyc();
    chk("flush_fcnt", {16'd0, flush_count}, 32'd1);
    chk("flush_scnt", {16'd0, stall_count}, 32'd1);
    drive(1, 9, 0, 2'b01, 0, 0, 0, 0, 0); #1;
    chk("flush_bubble_fwd", {28'd0, fwd_sel}, 32'h2);
    chk("flush_bubble_stall", {31'd0, stall}, 32'd0);
    cyc();

    // Freeze over a pending load-use, with flush also raised
    drive(1, 1, 0, 2'b01, 11, 1, 1, 0, 0); cyc();
    drive(1, 11, 0, 2'b01, 0, 0, 0, 1, 1); #1;
    chk("freeze_stall", {31'd0, stall}, 32'd0);
    cyc(); cyc(); cyc(); cyc();
    drive(1, 11, 0, 2'b01, 0, 0, 0, 0, 0); #1;
    chk("post_freeze_stall", {31'd0, stall}, 32'd1);
    chk("post_freeze_fwd", {28'd0, fwd_sel}, 32'h1);
    chk("post_freeze_fcnt", {16'd0, flush_count}, 32'd1);
    chk("post_freeze_scnt", {16'd0, stall_count}, 32'd1);
    cyc();
    chk("freeze_lu_scnt", {16'd0, stall_count}, 32'd2);
    chk("freeze_lu_fwd", {28'd0, fwd_sel}, 32'h2);
    chk("small_scnt", {30'd0, stall_count2}, 32'd2);
    cyc();

    // Register 0 is forwarded like any other
    drive(1, 0, 0, 2'b00, 0, 1, 0, 0, 0); cyc();
    drive(1, 0, 0, 2'b01, 0, 0, 0, 0, 0); #1;
    chk("r0_fwd", {28'd0, fwd_sel}, 32'h1);

    // Asynchronous reset mid-stream
    drive(1, 0, 0, 2'b00, 4, 1, 0, 0, 0); cyc();
    drive(1, 4, 0, 2'b01, 0, 0, 0, 0, 0); #1;
    chk("pre_reset_fwd", {28'd0, fwd_sel}, 32'h1);
    reset = 1'b1; #1;
    chk("async_reset_fwd", {28'd0, fwd_sel}, 32'h0);
    chk("async_reset_scnt", {16'd0, stall_count}, 32'd0);
    chk("async_reset_fcnt", {16'd0, flush_count}, 32'd0);
    reset = 1'b0;
    cyc();
    chk("post_reset_fwd", {28'd0, fwd_sel}, 32'h0);

    // Repeated load-use pairs to saturate the 2-bit counter
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 2'b01, 7, 1, 1, 0, 0); cyc();
      drive(1, 7, 0, 2'b01, 0, 0, 0, 0, 0); #1;
      chk("sat_stall", {31'd0, stall2}, 32'd1);
      cyc(); cyc();
      if (i == 1) chk("sat_small_mid", {30'd0, stall_count2}, 32'd2);
    end
    chk("sat_small_end", {30'd0, stall_count2}, 32'd3);
    chk("sat_big_end", {16'd0, stall_count}, 32'd5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Parametrised hazard-resolution unit for the multi-stage pipelined processor. It tracks in-flight register writes in a shift-register scoreboard and, for the instruction in decode, produces one operand-forwarding select per source. It raises a load-use stall when a needed value is not yet available and converts flushed or stalled slots into bubbles. It sits beside the decode pipeline register, consumes decoded register numbers and controller write/load flags, and drives the PC, IF and DEC register write enables plus the EX-stage operand muxes. It also keeps saturating stall and flush performance counters.

## Interface
- REG_INDEX_BIT_WIDTH, 4: register-number width.
- NUM_SRC, 2: source operands per instruction.
- DEPTH, 3: tracked stages after decode (EX, MEM, WB).
- LOAD_DIST, 2: minimum producer distance at which load data is forwardable.
- CNT_BITS, 16: performance-counter width.
- SEL_W, $clog2(DEPTH+1): width of one forwarding select.
- clk  in  1  processor clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- dec_valid  in  1  decode slot holds a real instruction.
- dec_src  in  NUM_SRC*REG_INDEX_BIT_WIDTH  source register numbers; source i is at [i*W +: W].
- dec_src_used  in  NUM_SRC  source i is actually read.
- dec_rd  in  REG_INDEX_BIT_WIDTH  destination register.
- dec_wr_reg  in  1  instruction writes dec_rd.
- dec_is_load  in  1  instruction's result comes from data memory.
- flush  in  1  taken branch: discard the decode-slot instruction.
- freeze  in  1  whole pipeline held, e.g. by an external memory wait.
- stall  out  1  hold PC, IF and DEC registers this cycle.
- fwd_sel  out  NUM_SRC*SEL_W  per source: 0 selects the register file; d in 1..DEPTH selects the producer d stages ahead.
- stall_count  out  CNT_BITS  cycles with stall=1 and freeze=0 (saturating).
- flush_count  out  CNT_BITS  cycles with flush=1 and freeze=0 (saturating).

## Operation
- Scoreboard: DEPTH entries of {valid, wr, rd, load}. Entry k holds the producer at distance k+1 from the decode instruction.
- Issue: each unfrozen cycle, entry 0 takes the decode instruction, or a bubble (valid=0) when stall, flush or !dec_valid. Entry k takes entry k-1. The last entry retires.
- Match for source i: entry k is valid, wr=1, rd equals the source, and dec_src_used[i]=1. The youngest match (smallest k) wins.
- fwd_sel[i] = k+1 for the winning entry, else 0. fwd_sel is driven even while stalling.
- Load-use: the winning entry has load=1 and k+1 < LOAD_DIST. Then stall=1 when dec_valid=1, flush=0 and freeze=0.
- Register 0 receives no special treatment; it is forwarded like any other register.
- Priority: freeze > flush > stall.
  - freeze=1: scoreboard and counters hold; stall=0.
  - flush=1: bubble issued; stall forced to 0.
- Counters saturate at 2^CNT_BITS-1 and never wrap.
- Purely combinational outputs: stall and fwd_sel, from the scoreboard and decode inputs only.
- No state machine beyond the scoreboard shift register and the counters.

## Timing
- Reset (asynchronous): all entries invalid, counters 0. Consequently stall=0 and fwd_sel=0 immediately after reset.
- Reset mid-operation: in-flight entries are dropped with no forwarding; the next instruction reads the register file.
- Load-use stall latency:
  - With LOAD_DIST=2: exactly one stall cycle for a dependent instruction immediately after a load.
  - With general LOAD_DIST: LOAD_DIST-1 stall cycles for back-to-back dependence.
- A producer at the last entry (WB) is still forwarded with d=DEPTH. This guarantees correctness regardless of regfile read/write ordering.
- After DEPTH unfrozen cycles with no writers, all fwd_sel return to 0.
- Simultaneous flush and load-use: flush wins. No stall is asserted, stall_count is unchanged and flush_count is incremented.

## Structure
- Shared package holds:
  - scoreboard entry typedef {valid, wr, rd, load};
  - FWD_RF = 0 constant;
  - default DEPTH and LOAD_DIST.
- Natural sub-module: sat_counter (CNT_BITS width, enable input, saturating), instantiated twice.
- Per-source match and priority logic uses a generate loop over NUM_SRC. It is not a separate module.

## Test plan
- Reset, then decode r3 with no producers → stall=0, fwd_sel=0. Assert reset mid-stream → scoreboard cleared on the same edge.
- ALU writes r5, then the next instruction reads r5 as src0 → fwd_sel[0]=1. One bubble between them → 2. Two bubbles → 3. Three bubbles → 0.
- Load to r7, then the immediate consumer of r7 → stall=1 for 1 cycle. Next cycle fwd_sel=2, stall=0, stall_count=1.
- r2 written at distances 1 and 3, consumer reads r2 on both sources → both fwd_sel=1 (youngest wins). dec_src_used=01 → source 1 select=0.
- Load-use with flush in the same cycle → stall=0, bubble enters entry 0, flush_count increments by 1. freeze=1 for 4 cycles → entries and counters unchanged.
- CNT_BITS=2, hold a load-use condition for 5 cycles → stall_count saturates at 3.
